// File: rtl/program_counter.sv
// Program counter register: holds the current instruction address and each
// rising edge either loads a jump target, increments by one, or holds.
module program_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             jump,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out
);

    // Jump outranks increment; the increment wraps modulo 2^WIDTH with no carry out.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of the order of the processes.
        if (!reset) begin
            out <= RESET_VALUE;
        end else if (jump) begin
            out <= data;
        end else if (inc) begin
            out <= out + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed checks from the test plan,
// then randomized traffic against an integer-arithmetic reference model.
module tb_program_counter;

    localparam int WIDTH = 16;
    localparam int MODULUS = 65536;

    logic             clk;
    logic             reset;
    logic             inc;
    logic             jump;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] out;

    int errors = 0;
    int checks = 0;
    int model  = 0;

    program_counter #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .jump  (jump),
        .data  (data),
        .out   (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // One rising edge: advance the reference model from the inputs presented at
    // the edge, compare just after it, then return on the falling edge where the
    // next inputs are driven.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!reset)      model = 0;
        else if (jump)   model = int'(data);
        else if (inc)    model = (model + 1) % MODULUS;
        #1;
        check(tag, out, WIDTH'(model));
        @(negedge clk);
    endtask

    // Assert reset between edges and confirm it clears the counter without a clock.
    task automatic mid_reset_pulse(input string tag);
        #2 reset = 1'b0;
        #1;
        model = 0;
        check(tag, out, WIDTH'(model));
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        inc   = 1'b0;
        jump  = 1'b0;
        data  = '0;

        // Async reset with no clock edge, then held across a clock pulse.
        #1 reset = 1'b0;
        #1 check("async_reset", out, '0);
        tick("reset_held_over_edge");

        // Increment twice, then hold.
        reset = 1'b1;
        inc   = 1'b1;
        tick("inc_to_1");
        tick("inc_to_2");
        inc = 1'b0;
        tick("hold_at_2");

        // Load and hold.
        data = 16'd1997;
        jump = 1'b1;
        tick("jump_1997");
        jump = 1'b0;
        tick("hold_1997");

        // Precedence: reset over everything, jump over inc.
        inc   = 1'b1;
        jump  = 1'b1;
        reset = 1'b0;
        #1;
        model = 0;
        check("reset_beats_inc_jump", out, '0);
        tick("reset_beats_edge");
        reset = 1'b1;
        data  = 16'd1997;
        tick("jump_beats_inc");
        jump = 1'b0;
        tick("inc_to_1998");

        // Wrap-around from all ones.
        data = 16'hFFFF;
        jump = 1'b1;
        inc  = 1'b0;
        tick("jump_ffff");
        jump = 1'b0;
        inc  = 1'b1;
        tick("wrap_to_0");

        // Count to 5, reset between edges, restart counting.
        for (int i = 0; i < 5; i++) tick("count_up");
        check("counted_to_5", out, 16'd5);
        mid_reset_pulse("mid_cycle_reset");
        tick("restart_to_1");

        // Randomized traffic; inputs wiggle between edges to confirm they do not leak to out.
        for (int n = 0; n < 400; n++) begin
            inc  = 1'($urandom_range(0, 1));
            jump = ($urandom_range(0, 9) == 0);
            data = WIDTH'($urandom);
            if ($urandom_range(0, 15) == 0) data = 16'hFFFF;
            if ($urandom_range(0, 24) == 0) begin
                mid_reset_pulse("rand_mid_reset");
            end else begin
                #2;
                check("rand_between_edges", out, WIDTH'(model));
            end
            tick("rand_edge");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
